// File: rtl/uart_sipo_rx.sv
// ---------------------------------------------------------------------------
// uart_sipo_rx
// UART receiver (serial in, parallel out). Oversamples data_rx on baud_clk,
// validates the start bit at mid-bit, then shifts in 8 data bits LSB first,
// followed by a parity bit and a stop bit. A completed frame loads data_out
// and the error flags, and pulses done_flag for one cycle.
//
// Ports
//   baud_clk    in   clock, OVERSAMPLE x bit rate
//   reset       in   asynchronous reset, active low
//   data_rx     in   asynchronous serial line, idles high
//   parity_bit  in   parity mode: 0 = even, 1 = odd
//   data_out    out  last received byte, held until the next frame completes
//   active_flag out  high while a frame is in progress (START..STOP)
//   done_flag   out  one-cycle pulse when a frame completes
//   parity_err  out  parity error of the last frame
//   frame_err   out  stop bit of the last frame sampled 0
// ---------------------------------------------------------------------------
module uart_sipo_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       baud_clk,
    input  logic       reset,
    input  logic       data_rx,
    input  logic       parity_bit,
    output logic [7:0] data_out,
    output logic       active_flag,
    output logic       done_flag,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            perr_q, perr_d;      // parity result of the frame in flight
    logic [7:0]      data_q, data_d;
    logic            par_err_q, par_err_d;
    logic            frm_err_q, frm_err_d;
    logic            done_q, done_d;
    logic            sync1_q, sync2_q;
    logic            rx_s;

    assign rx_s        = sync2_q;
    assign data_out    = data_q;
    assign done_flag   = done_q;
    assign parity_err  = par_err_q;
    assign frame_err   = frm_err_q;
    // Decoded from the state register, so it drops on the same edge that
    // raises done_flag (STOP -> IDLE/BREAK).
    assign active_flag = (state_q == S_START) || (state_q == S_DATA) ||
                         (state_q == S_PARITY) || (state_q == S_STOP);

    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync1_q   <= data_rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // Mid start bit: a line that has gone high again was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end
            end
            S_DATA: begin
                // Explicit wrap keeps the bit period right for non power-of-2
                // OVERSAMPLE values.
                if (cnt_q == LAST) begin
                    cnt_d               = '0;
                    shift_d[idx_q[2:0]] = rx_s;
                    if (idx_q == 4'd7) state_d = S_PARITY;
                    else               idx_d   = idx_q + 4'd1;
                end
            end
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    perr_d  = ^{shift_q, rx_s, parity_bit};
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid stop bit leaves half a bit of margin to catch
                // the next start edge in back-to-back traffic.
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    data_d    = shift_q;
                    par_err_d = perr_q;
                    frm_err_d = ~rx_s;
                    done_d    = 1'b1;
                    state_d   = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // Held-low line: wait for idle so it is not taken as new frames.
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_sipo_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_sipo_rx
// Directed bench for uart_sipo_rx with OVERSAMPLE = 16. Inputs change on the
// falling edge; a falling-edge monitor logs every done_flag pulse with its
// cycle number and the outputs, and tracks active_flag.
// ---------------------------------------------------------------------------
module tb_uart_sipo_rx;

    localparam int OS = 16;

    logic       baud_clk = 1'b0;
    logic       reset;
    logic       data_rx;
    logic       parity_bit;
    logic [7:0] data_out;
    logic       active_flag;
    logic       done_flag;
    logic       parity_err;
    logic       frame_err;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // done_flag log
    int         q_cyc[$];
    logic [7:0] q_data[$];
    logic       q_perr[$];
    logic       q_ferr[$];
    int         dbl_cnt  = 0;
    logic       done_prev = 1'b0;

    // active_flag tracking
    logic act_prev = 1'b0;
    int   act_rise = -1;
    int   act_fall = -1;
    int   act_cnt  = 0;

    uart_sipo_rx #(.OVERSAMPLE(OS)) dut (
        .baud_clk   (baud_clk),
        .reset      (reset),
        .data_rx    (data_rx),
        .parity_bit (parity_bit),
        .data_out   (data_out),
        .active_flag(active_flag),
        .done_flag  (done_flag),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) cyc <= cyc + 1;

    always @(negedge baud_clk) begin
        if (done_flag) begin
            q_cyc.push_back(cyc);
            q_data.push_back(data_out);
            q_perr.push_back(parity_err);
            q_ferr.push_back(frame_err);
            if (done_prev) dbl_cnt++;
        end
        done_prev = done_flag;
        if (active_flag && !act_prev) act_rise = cyc;
        if (!active_flag && act_prev) act_fall = cyc;
        if (active_flag) act_cnt++;
        act_prev = active_flag;
    end

    task automatic clear_log();
        q_cyc.delete();
        q_data.delete();
        q_perr.delete();
        q_ferr.delete();
    endtask

    task automatic drive_bit(input logic v);
        data_rx = v;
        repeat (OS) @(negedge baud_clk);
    endtask

    // Called just after a falling edge; t0 is the cycle number of E0.
    task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                              output int t0);
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        cmp_cnt += 5;
        if (data_out !== 8'h00) begin err_cnt++; $display("FAIL rst_data: got %h want 00", data_out); end
        if (active_flag !== 1'b0) begin err_cnt++; $display("FAIL rst_active: got %b want 0", active_flag); end
        if (done_flag !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b want 0", done_flag); end
        if (parity_err !== 1'b0) begin err_cnt++; $display("FAIL rst_perr: got %b want 0", parity_err); end
        if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
        repeat (3) @(negedge baud_clk);
        reset = 1'b1;
        repeat (8) @(negedge baud_clk);
    endtask

    task automatic test_nominal();
        int t0;
        parity_bit = 1'b0;
        clear_log();
        act_rise = -1;
        act_fall = -1;
        send_frame(8'h4A, 1'b1, 1'b1, t0);
        repeat (16) @(negedge baud_clk);
        cmp_cnt += 3;
        if (q_cyc.size() !== 1) begin err_cnt++; $display("FAIL nom_count: got %0d want 1", q_cyc.size()); end
        if (act_rise !== t0 + 2) begin err_cnt++; $display("FAIL nom_act_rise: got %0d want %0d", act_rise - t0, 2); end
        if (act_fall !== t0 + 170) begin err_cnt++; $display("FAIL nom_act_fall: got %0d want %0d", act_fall - t0, 170); end
        if (q_cyc.size() >= 1) begin
            cmp_cnt += 4;
            if (q_cyc[0] !== t0 + 170) begin err_cnt++; $display("FAIL nom_done_time: got E%0d want E170", q_cyc[0] - t0); end
            if (q_data[0] !== 8'h4A) begin err_cnt++; $display("FAIL nom_data: got %h want 4a", q_data[0]); end
            if (q_perr[0] !== 1'b0) begin err_cnt++; $display("FAIL nom_perr: got %b want 0", q_perr[0]); end
            if (q_ferr[0] !== 1'b0) begin err_cnt++; $display("FAIL nom_ferr: got %b want 0", q_ferr[0]); end
        end
    endtask

    task automatic test_reset_midframe();
        int t0;
        parity_bit = 1'b0;
        clear_log();
        data_rx = 1'b0;                        // start bit
        repeat (OS) @(negedge baud_clk);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h4A >> i));
        data_rx = 1'b0;                        // into d4
        repeat (2) @(negedge baud_clk);
        // Transmitter resets with the receiver, so the line returns to idle.
        reset   = 1'b0;
        data_rx = 1'b1;
        #1;
        cmp_cnt += 5;
        if (data_out !== 8'h00) begin err_cnt++; $display("FAIL mid_rst_data: got %h want 00", data_out); end
        if (active_flag !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_active: got %b want 0", active_flag); end
        if (done_flag !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_done: got %b want 0", done_flag); end
        if (parity_err !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_perr: got %b want 0", parity_err); end
        if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_ferr: got %b want 0", frame_err); end
        repeat (3) @(negedge baud_clk);
        reset = 1'b1;
        repeat (3 * OS) @(negedge baud_clk);
        cmp_cnt++;
        if (q_cyc.size() !== 0) begin err_cnt++; $display("FAIL mid_rst_nodone: got %0d pulses want 0", q_cyc.size()); end
        send_frame(8'h4A, 1'b1, 1'b1, t0);
        repeat (16) @(negedge baud_clk);
        cmp_cnt++;
        if (q_cyc.size() !== 1) begin err_cnt++; $display("FAIL mid_rst_next_count: got %0d want 1", q_cyc.size()); end
        if (q_cyc.size() >= 1) begin
            cmp_cnt += 3;
            if (q_cyc[0] !== t0 + 170) begin err_cnt++; $display("FAIL mid_rst_next_time: got E%0d want E170", q_cyc[0] - t0); end
            if (q_data[0] !== 8'h4A) begin err_cnt++; $display("FAIL mid_rst_next_data: got %h want 4a", q_data[0]); end
            if ({q_perr[0], q_ferr[0]} !== 2'b00) begin err_cnt++; $display("FAIL mid_rst_next_err: got %b%b want 00", q_perr[0], q_ferr[0]); end
        end
    endtask

    task automatic test_parity();
        int t0;
        parity_bit = 1'b1;                     // odd
        clear_log();
        send_frame(8'h5A, 1'b0, 1'b1, t0);     // four ones + 0: wrong for odd
        repeat (16) @(negedge baud_clk);
        send_frame(8'h5A, 1'b1, 1'b1, t0);     // correct odd parity
        repeat (16) @(negedge baud_clk);
        cmp_cnt++;
        if (q_cyc.size() !== 2) begin err_cnt++; $display("FAIL par_count: got %0d want 2", q_cyc.size()); end
        if (q_cyc.size() >= 2) begin
            cmp_cnt += 5;
            if (q_data[0] !== 8'h5A) begin err_cnt++; $display("FAIL par_data: got %h want 5a", q_data[0]); end
            if (q_perr[0] !== 1'b1) begin err_cnt++; $display("FAIL par_err_set: got %b want 1", q_perr[0]); end
            if (q_ferr[0] !== 1'b0) begin err_cnt++; $display("FAIL par_ferr: got %b want 0", q_ferr[0]); end
            if (q_perr[1] !== 1'b0) begin err_cnt++; $display("FAIL par_err_clear: got %b want 0", q_perr[1]); end
            if (q_data[1] !== 8'h5A) begin err_cnt++; $display("FAIL par_data2: got %h want 5a", q_data[1]); end
        end
        parity_bit = 1'b0;
    endtask

    task automatic test_break();
        int t0;
        int t1;
        parity_bit = 1'b0;
        clear_log();
        send_frame(8'h00, 1'b0, 1'b0, t0);     // stop bit low
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        data_rx = 1'b1;
        repeat (32) @(negedge baud_clk);
        cmp_cnt++;
        if (q_cyc.size() !== 1) begin err_cnt++; $display("FAIL brk_count: got %0d want 1", q_cyc.size()); end
        if (q_cyc.size() >= 1) begin
            cmp_cnt += 4;
            if (q_cyc[0] !== t0 + 170) begin err_cnt++; $display("FAIL brk_time: got E%0d want E170", q_cyc[0] - t0); end
            if (q_data[0] !== 8'h00) begin err_cnt++; $display("FAIL brk_data: got %h want 00", q_data[0]); end
            if (q_ferr[0] !== 1'b1) begin err_cnt++; $display("FAIL brk_ferr: got %b want 1", q_ferr[0]); end
            if (q_perr[0] !== 1'b0) begin err_cnt++; $display("FAIL brk_perr: got %b want 0", q_perr[0]); end
        end
        send_frame(8'hA5, 1'b0, 1'b1, t1);
        repeat (16) @(negedge baud_clk);
        cmp_cnt++;
        if (q_cyc.size() !== 2) begin err_cnt++; $display("FAIL brk_next_count: got %0d want 2", q_cyc.size()); end
        if (q_cyc.size() >= 2) begin
            cmp_cnt += 2;
            if (q_data[1] !== 8'hA5) begin err_cnt++; $display("FAIL brk_next_data: got %h want a5", q_data[1]); end
            if ({q_perr[1], q_ferr[1]} !== 2'b00) begin err_cnt++; $display("FAIL brk_next_err: got %b%b want 00", q_perr[1], q_ferr[1]); end
        end
    endtask

    task automatic test_false_start();
        clear_log();
        act_cnt = 0;
        data_rx = 1'b0;
        repeat (4) @(negedge baud_clk);
        data_rx = 1'b1;
        repeat (40) @(negedge baud_clk);
        cmp_cnt += 3;
        if (act_cnt !== 8) begin err_cnt++; $display("FAIL fs_active_cycles: got %0d want 8", act_cnt); end
        if (q_cyc.size() !== 0) begin err_cnt++; $display("FAIL fs_nodone: got %0d pulses want 0", q_cyc.size()); end
        if (data_out !== 8'hA5) begin err_cnt++; $display("FAIL fs_data_hold: got %h want a5", data_out); end
    endtask

    task automatic test_back_to_back();
        int t0;
        int tx;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'h4A;
        parity_bit = 1'b0;
        clear_log();
        send_frame(8'h00, 1'b0, 1'b1, t0);
        send_frame(8'hFF, 1'b0, 1'b1, tx);
        send_frame(8'h4A, 1'b1, 1'b1, tx);
        repeat (16) @(negedge baud_clk);
        cmp_cnt++;
        if (q_cyc.size() !== 3) begin err_cnt++; $display("FAIL b2b_count: got %0d want 3", q_cyc.size()); end
        if (q_cyc.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                cmp_cnt += 3;
                if (q_cyc[i] !== t0 + 170 + 176 * i) begin err_cnt++; $display("FAIL b2b_time%0d: got E%0d want E%0d", i, q_cyc[i] - t0, 170 + 176 * i); end
                if (q_data[i] !== exp_b[i]) begin err_cnt++; $display("FAIL b2b_data%0d: got %h want %h", i, q_data[i], exp_b[i]); end
                if ({q_perr[i], q_ferr[i]} !== 2'b00) begin err_cnt++; $display("FAIL b2b_err%0d: got %b%b want 00", i, q_perr[i], q_ferr[i]); end
            end
        end
    endtask

    task automatic test_done_single();
        cmp_cnt++;
        if (dbl_cnt !== 0) begin err_cnt++; $display("FAIL done_width: got %0d double pulses want 0", dbl_cnt); end
    endtask

    initial begin
        data_rx    = 1'b1;
        parity_bit = 1'b0;
        reset      = 1'b1;
        @(negedge baud_clk);
        test_reset();
        test_nominal();
        test_reset_midframe();
        test_parity();
        test_break();
        test_false_start();
        repeat (32) @(negedge baud_clk);
        test_back_to_back();
        test_done_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
